// File: rtl/fpga_io_router_pkg.sv
// ----------------------------------------------------------------------------
// fpga_io_router_pkg
//   Shared encodings for the pad/fabric crossbar: pad modes, register
//   offsets inside the 4 KiB wishbone window, MAP field layout and a helper
//   that packs one MAP entry into its 32-bit read value.
//   Optional build macro honoured by the top: FPGA_IO_LOOPBACK_EN.
// ----------------------------------------------------------------------------
package fpga_io_router_pkg;

   localparam int IDX_W    = 6;
   localparam int MODE_LSB = 8;
   localparam int MODE_W   = 2;
   localparam int WORD_W   = 10;   // word index inside the 4 KiB window

   typedef enum logic [MODE_W-1:0] {
      MODE_DIS = 2'b00,
      MODE_IN  = 2'b01,
      MODE_OUT = 2'b10,
      MODE_RSV = 2'b11            // decodes as disabled
   } pad_mode_e;

   localparam logic [11:0] CTRL_OFF   = 12'h100;
   localparam logic [11:0] STATUS_OFF = 12'h104;

   localparam logic [WORD_W-1:0] CTRL_WORD   = CTRL_OFF[11:2];
   localparam logic [WORD_W-1:0] STATUS_WORD = STATUS_OFF[11:2];

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_LOCK_BIT = 1;
   localparam int CTRL_LB_BIT   = 2;

   function automatic logic [31:0] map_rdata(input pad_mode_e mode,
                                             input logic [IDX_W-1:0] idx);
      return {22'b0, mode, 2'b0, idx};
   endfunction

endpackage

// File: rtl/fpga_io_router_sync.sv
// ----------------------------------------------------------------------------
// fpga_io_sync
//   WIDTH-bit, STAGES-deep flop chain used to bring asynchronous pad inputs
//   into the wishbone clock domain. Synchronous active-high reset clears
//   every stage.
// Ports:
//   clk_sys  clock
//   rst      synchronous reset, active-high
//   d        asynchronous input bits
//   q        synchronised output bits (STAGES cycles of latency)
// ----------------------------------------------------------------------------
module fpga_io_sync #(
   parameter int WIDTH  = 38,
   parameter int STAGES = 2
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int s = 1; s < STAGES; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fpga_io_router.sv
// ----------------------------------------------------------------------------
// fpga_io_router
//   Wishbone-programmable crossbar between the fabric GPIO bus and the user
//   pads. Each pad owns a MAP register (fabric index + mode). Output-mode pads
//   drive a registered copy of the selected fabric bit; input-mode pads feed
//   their synchronised value back to the selected fabric bit, lowest pad
//   winning when several pads claim the same index.
//   Build macro: FPGA_IO_LOOPBACK_EN adds CTRL bit2 (fabric loopback).
// Ports:
//   wb_clk_i / wb_rst_i      clock, synchronous active-high reset
//   wbs_*                    wishbone slave (registered single-cycle ack)
//   fabric_out / fabric_in   fabric GPIO bus (from / to the fabric)
//   io_in / io_out / io_oeb  pad side, io_oeb active-low
// ----------------------------------------------------------------------------
module fpga_io_router
   import fpga_io_router_pkg::*;
#(
   parameter int          NUM_PADS      = 38,
   parameter int          NUM_FABRIC_IO = 38,
   parameter logic [31:0] BASE_ADDR     = 32'h3000_1000,
   parameter int          SYNC_STAGES   = 2
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_dat_i,
   input  logic [31:0]              wbs_adr_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [NUM_FABRIC_IO-1:0] fabric_out,
   output logic [NUM_FABRIC_IO-1:0] fabric_in,
   input  logic [NUM_PADS-1:0]      io_in,
   output logic [NUM_PADS-1:0]      io_out,
   output logic [NUM_PADS-1:0]      io_oeb
);

   // ---------------------------------------------------------------- decode
   logic              in_window;
   logic              bus_req;
   logic              bus_wr;
   logic              bus_rd;
   logic [WORD_W-1:0] word_sel;

   assign in_window = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
   assign word_sel  = wbs_adr_i[11:2];
   // Holding off while ack is high keeps a still-asserted strobe from
   // being taken as a second request in the ack cycle.
   assign bus_req   = wbs_stb_i & wbs_cyc_i & in_window & ~wbs_ack_o;
   assign bus_wr    = bus_req & wbs_we_i;
   assign bus_rd    = bus_req & ~wbs_we_i;

   // -------------------------------------------------------- register file
   logic [IDX_W-1:0] map_idx  [NUM_PADS];
   pad_mode_e        map_mode [NUM_PADS];
   logic             ctrl_en;
   logic             ctrl_lock;
   logic             ctrl_lb;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            map_idx[p]  <= '0;
            map_mode[p] <= MODE_DIS;
         end
         ctrl_en   <= 1'b0;
         ctrl_lock <= 1'b0;
      end else if (bus_wr) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            if (word_sel == WORD_W'(p) && !ctrl_lock) begin
               if (wbs_sel_i[0]) map_idx[p]  <= wbs_dat_i[IDX_W-1:0];
               if (wbs_sel_i[1]) map_mode[p] <= pad_mode_e'(wbs_dat_i[MODE_LSB +: MODE_W]);
            end
         end
         if (word_sel == CTRL_WORD && wbs_sel_i[0]) begin
            if (!ctrl_lock) ctrl_en <= wbs_dat_i[CTRL_EN_BIT];
            // Lock is sticky: only a 1 is written, reset is the only way out.
            if (wbs_dat_i[CTRL_LOCK_BIT]) ctrl_lock <= 1'b1;
         end
      end
   end

`ifdef FPGA_IO_LOOPBACK_EN
   // Loopback is deliberately outside the lock so it stays usable for
   // bring-up after the pad map has been frozen.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ctrl_lb <= 1'b0;
      end else if (bus_wr && word_sel == CTRL_WORD && wbs_sel_i[0]) begin
         ctrl_lb <= wbs_dat_i[CTRL_LB_BIT];
      end
   end
`else
   assign ctrl_lb = 1'b0;
`endif

   // ------------------------------------------------------------ read mux
   logic [31:0] rd_data;

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         if (word_sel == WORD_W'(p)) rd_data = map_rdata(map_mode[p], map_idx[p]);
      end
      if (word_sel == CTRL_WORD) begin
         rd_data = {29'b0, ctrl_lb, ctrl_lock, ctrl_en};
      end
      if (word_sel == STATUS_WORD) begin
         rd_data = {16'b0, 8'(NUM_FABRIC_IO), 8'(NUM_PADS)};
      end
   end

   // ------------------------------------------------------------ handshake
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= bus_req;
         wbs_dat_o <= bus_rd ? rd_data : '0;
      end
   end

   // ---------------------------------------------------------- output path
   // Fabric bus widened to the full index range so a 6-bit index always
   // selects a real bit; out-of-range indices are excluded by drive_en.
   logic [63:0]         fabric_out_ext;
   logic [NUM_PADS-1:0] drive_en;

   assign fabric_out_ext = 64'(fabric_out);

   always_comb begin
      drive_en = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         drive_en[p] = ctrl_en && !ctrl_lb && (map_mode[p] == MODE_OUT)
                       && (int'(map_idx[p]) < NUM_FABRIC_IO);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         io_out <= '0;
         io_oeb <= '1;
      end else begin
         for (int p = 0; p < NUM_PADS; p++) begin
            io_out[p] <= drive_en[p] & fabric_out_ext[map_idx[p]];
            io_oeb[p] <= ~drive_en[p];
         end
      end
   end

   // ----------------------------------------------------------- input path
   logic [NUM_PADS-1:0] io_sync;
   logic [63:0]         in_mux_ext;

   fpga_io_sync #(
      .WIDTH  (NUM_PADS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_sys (wb_clk_i),
      .rst     (wb_rst_i),
      .d       (io_in),
      .q       (io_sync)
   );

   // Walking from the highest pad down lets the lowest-numbered claimant
   // overwrite any other pad mapped to the same fabric index.
   always_comb begin
      in_mux_ext = '0;
      for (int p = NUM_PADS - 1; p >= 0; p--) begin
         if (ctrl_en && (map_mode[p] == MODE_IN) && (int'(map_idx[p]) < NUM_FABRIC_IO)) begin
            in_mux_ext[map_idx[p]] = io_sync[p];
         end
      end
   end

`ifdef FPGA_IO_LOOPBACK_EN
   logic [NUM_FABRIC_IO-1:0] loop_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         loop_q <= '0;
      end else begin
         loop_q <= fabric_out;
      end
   end

   assign fabric_in = ctrl_lb ? loop_q : in_mux_ext[NUM_FABRIC_IO-1:0];
`else
   assign fabric_in = in_mux_ext[NUM_FABRIC_IO-1:0];
`endif

   // Address byte offset, upper data bits and upper lanes carry nothing here.
   logic unused_bits;
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i[3:2], in_mux_ext};

endmodule
